// File: rtl/index_walk_scheduler.sv
// Round-robin shared index-walk engine: latches one requester's (base, count) job and
// streams index addresses on a valid/ready port. Optional per-job stride: INDEX_WALK_STRIDE_EN.
`ifndef INDEX_NUM_LOG
`define INDEX_NUM_LOG 6
`endif

module index_walk_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int OWNER_W = $clog2(NUM_REQ)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*`INDEX_NUM_LOG-1:0] req_count,
  input  logic [NUM_REQ*ADDR_W-1:0]         req_base,
`ifdef INDEX_WALK_STRIDE_EN
  input  logic [NUM_REQ*ADDR_W-1:0]         req_stride,
`endif
  output logic [NUM_REQ-1:0]                req_grant,
  output logic                              idx_valid,
  output logic [ADDR_W-1:0]                 idx_addr,
  output logic [OWNER_W-1:0]                idx_owner,
  output logic                              idx_last,
  input  logic                              idx_ready,
  output logic [NUM_REQ-1:0]                done,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  localparam int CNT_W = `INDEX_NUM_LOG;

  // Handshake: a beat transfers when idx_valid && idx_ready on a rising clock edge;
  // once raised, idx_valid stays high with addr/owner/last stable until the beat transfers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ZERO  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [ADDR_W-1:0]  step;

  logic               found;
  logic [OWNER_W-1:0] win;
  logic [OWNER_W-1:0] next_ptr;
  logic [ADDR_W-1:0]  sel_base;
  logic [CNT_W-1:0]   sel_count;

`ifdef INDEX_WALK_STRIDE_EN
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [ADDR_W-1:0]  sel_stride;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Search from the pointer upward first, then wrap to the low requesters.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        found = 1'b1;
        win   = OWNER_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i < int'(rr_ptr_q))) begin
        found = 1'b1;
        win   = OWNER_W'(i);
      end
    end
  end

  always_comb begin
    sel_base  = '0;
    sel_count = '0;
`ifdef INDEX_WALK_STRIDE_EN
    sel_stride = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == OWNER_W'(i)) begin
        sel_base  = req_base[i*ADDR_W +: ADDR_W];
        sel_count = req_count[i*CNT_W +: CNT_W];
`ifdef INDEX_WALK_STRIDE_EN
        sel_stride = req_stride[i*ADDR_W +: ADDR_W];
`endif
      end
    end
    next_ptr = (win == OWNER_W'(NUM_REQ-1)) ? '0 : OWNER_W'(win + 1'b1);
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    done_d      = '0;
    req_grant   = '0;
`ifdef INDEX_WALK_STRIDE_EN
    stride_d    = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          req_grant[win] = 1'b1;
          cur_addr_d     = sel_base;
          remaining_d    = sel_count;
          owner_d        = win;
          rr_ptr_d       = next_ptr;
`ifdef INDEX_WALK_STRIDE_EN
          stride_d       = sel_stride;
`endif
          if (sel_count == '0) begin
            // Empty job completes in the following ZERO cycle.
            state_d     = ZERO;
            done_d[win] = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (idx_ready) begin
          cur_addr_d  = cur_addr_q + step;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d         = IDLE;
            done_d[owner_q] = 1'b1;
          end
        end
      end
      ZERO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      done_q      <= done_d;
    end
  end

`ifdef INDEX_WALK_STRIDE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end
`endif

  assign idx_valid = (state_q == ISSUE);
  assign idx_addr  = cur_addr_q;
  assign idx_owner = owner_q;
  assign idx_last  = (state_q == ISSUE) && (remaining_q == CNT_W'(1));
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_index_walk_scheduler.sv
// Bench for index_walk_scheduler: job-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
`ifndef INDEX_NUM_LOG
`define INDEX_NUM_LOG 6
`endif

module tb_index_walk_scheduler;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int CW = `INDEX_NUM_LOG;
  localparam int OW = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid = '0;
  logic [N*CW-1:0] req_count = '0;
  logic [N*AW-1:0] req_base  = '0;
`ifdef INDEX_WALK_STRIDE_EN
  logic [N*AW-1:0] req_stride = '0;
`endif
  logic            idx_ready = 1'b1;
  logic [N-1:0]    req_grant;
  logic            idx_valid;
  logic [AW-1:0]   idx_addr;
  logic [OW-1:0]   idx_owner;
  logic            idx_last;
  logic [N-1:0]    done;
  logic            busy;
  logic [1:0]      dbg_state;

  index_walk_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .OWNER_W(OW)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_count(req_count),
    .req_base(req_base),
`ifdef INDEX_WALK_STRIDE_EN
    .req_stride(req_stride),
`endif
    .req_grant(req_grant),
    .idx_valid(idx_valid),
    .idx_addr(idx_addr),
    .idx_owner(idx_owner),
    .idx_last(idx_last),
    .idx_ready(idx_ready),
    .done(done),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];       // literal beat addresses, in order
  logic [N-1:0]  pin_grant_q[$]; // literal grant vectors, in order
  logic [N-1:0]  pin_done_q[$];  // literal done vectors, in order
  logic [N-1:0]  last_grant = '0;
  bit end_req  = 1'b0;
  bit end_done = 1'b0;
  bit rr_hold  = 1'b0;

  // Job-level reference model
  bit            armed = 1'b0;
  bit            m_active = 1'b0;
  int            m_left = 0;
  int            m_owner = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_stride = '0;
  logic [N-1:0]  m_done = '0;
  bit            prev_reset = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  logic [N-1:0] eg, nd;
  bit ev, el, fnd;
  int w, c;

  always @(negedge clock) begin
    eg  = '0;
    fnd = 1'b0;
    w   = 0;
    if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!fnd && req_valid[c]) begin
          fnd = 1'b1;
          w   = c;
        end
      end
      if (fnd) eg[w] = 1'b1;
    end
    ev = m_active && (m_left != 0);
    el = ev && (m_left == 1);

    if (armed) begin
      chk("grant", {28'd0, req_grant}, {28'd0, eg});
      chk("idx_valid", {31'd0, idx_valid}, {31'd0, ev});
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("done", {28'd0, done}, {28'd0, m_done});
      if (ev) begin
        chk("idx_addr", {16'd0, idx_addr}, {16'd0, m_addr});
        chk("idx_last", {31'd0, idx_last}, {31'd0, el});
      end
      if (m_active) chk("idx_owner", {30'd0, idx_owner}, 32'(m_owner));
      if (prev_reset && !reset) begin
        chk("rst_idx_valid", {31'd0, idx_valid}, 32'd0);
        chk("rst_idx_last", {31'd0, idx_last}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_idx_addr", {16'd0, idx_addr}, 32'd0);
        chk("rst_idx_owner", {30'd0, idx_owner}, 32'd0);
      end
      if (eg != '0 && pin_grant_q.size() > 0)
        chk("pin_grant", {28'd0, req_grant}, {28'd0, pin_grant_q.pop_front()});
      if (ev && idx_ready && !reset && exp_q.size() > 0)
        chk("pin_addr", {16'd0, idx_addr}, {16'd0, exp_q.pop_front()});
      if (m_done != '0 && pin_done_q.size() > 0)
        chk("pin_done", {28'd0, done}, {28'd0, pin_done_q.pop_front()});
      if (end_req && !end_done) begin
        chk("pins_left", 32'(exp_q.size() + pin_grant_q.size() + pin_done_q.size()), 32'd0);
        end_done = 1'b1;
      end
    end
    last_grant = eg;
    prev_reset = reset;

    nd = '0;
    if (reset) begin
      m_active = 1'b0;
      m_left   = 0;
      m_ptr    = 0;
      m_done   = '0;
      armed    = 1'b1;
    end else begin
      if (m_active) begin
        if (m_left == 0) begin
          m_active = 1'b0;
        end else if (idx_ready) begin
`ifdef INDEX_WALK_STRIDE_EN
          m_addr = m_addr + m_stride;
`else
          m_addr = m_addr + 16'd1;
`endif
          m_left--;
          if (m_left == 0) begin
            m_active    = 1'b0;
            nd[m_owner] = 1'b1;
          end
        end
      end else if (fnd) begin
        m_active = 1'b1;
        m_owner  = w;
        m_addr   = req_base[w*AW +: AW];
        m_left   = int'(req_count[w*CW +: CW]);
`ifdef INDEX_WALK_STRIDE_EN
        m_stride = req_stride[w*AW +: AW];
`endif
        m_ptr    = (w + 1) % N;
        if (m_left == 0) nd[w] = 1'b1;
      end
      m_done = nd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    if (!rr_hold) req_valid = req_valid & ~last_grant;
  endtask

  task automatic submit(input int i, input logic [AW-1:0] base, input int cnt,
                        input logic [AW-1:0] stride);
    req_valid[i] = 1'b1;
    req_base[i*AW +: AW] = base;
    req_count[i*CW +: CW] = CW'(cnt);
`ifdef INDEX_WALK_STRIDE_EN
    req_stride[i*AW +: AW] = stride;
`else
    if (stride != stride) $display("unreachable");
`endif
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    idx_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    ticks(2);
    reset = 1'b0;

    // Single job, ready held high
    do_reset();
    submit(0, 16'h0100, 3, 16'd1);
    pin_grant_q.push_back(4'b0001);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0101); exp_q.push_back(16'h0102);
    pin_done_q.push_back(4'b0001);
    ticks(6);

    // Backpressure on the first beat
    do_reset();
    submit(0, 16'h0100, 2, 16'd1);
    pin_grant_q.push_back(4'b0001);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
    pin_done_q.push_back(4'b0001);
    tick();
    idx_ready = 1'b0;
    ticks(3);
    idx_ready = 1'b1;
    ticks(4);

    // Round robin with all requesters continuously valid
    do_reset();
    for (int i = 0; i < N; i++) submit(i, 16'(i * 16), 1, 16'd1);
    pin_grant_q.push_back(4'b0001); pin_grant_q.push_back(4'b0010);
    pin_grant_q.push_back(4'b0100); pin_grant_q.push_back(4'b1000);
    pin_grant_q.push_back(4'b0001);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0020); exp_q.push_back(16'h0030);
    exp_q.push_back(16'h0000);
    pin_done_q.push_back(4'b0001); pin_done_q.push_back(4'b0010);
    pin_done_q.push_back(4'b0100); pin_done_q.push_back(4'b1000);
    pin_done_q.push_back(4'b0001);
    rr_hold = 1'b1;
    ticks(9);
    rr_hold = 1'b0;
    req_valid = '0;
    ticks(4);

    // Zero count, then address wrap
    do_reset();
    submit(2, 16'h0500, 0, 16'd1);
    pin_grant_q.push_back(4'b0100);
    pin_done_q.push_back(4'b0100);
    tick();
    submit(1, 16'hFFFF, 2, 16'd1);
    pin_grant_q.push_back(4'b0010);
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
    pin_done_q.push_back(4'b0010);
    ticks(6);

    // Reset in the middle of a job
    do_reset();
    submit(0, 16'h0200, 5, 16'd1);
    pin_grant_q.push_back(4'b0001);
    exp_q.push_back(16'h0200); exp_q.push_back(16'h0201);
    ticks(3);
    idx_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idx_ready = 1'b1;
    submit(2, 16'h0400, 1, 16'd1);
    submit(0, 16'h0300, 1, 16'd1);
    pin_grant_q.push_back(4'b0001); pin_grant_q.push_back(4'b0100);
    exp_q.push_back(16'h0300); exp_q.push_back(16'h0400);
    pin_done_q.push_back(4'b0001); pin_done_q.push_back(4'b0100);
    ticks(6);

`ifdef INDEX_WALK_STRIDE_EN
    do_reset();
    submit(3, 16'h0010, 3, 16'd4);
    pin_grant_q.push_back(4'b1000);
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0014); exp_q.push_back(16'h0018);
    pin_done_q.push_back(4'b1000);
    ticks(6);
`endif

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          submit(i,
                 ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                             : 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, (1 << CW) - 1))
                                              : int'($urandom_range(0, 4)),
                 16'($urandom_range(0, 8)));
        end
      end
      idx_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    req_valid = '0;
    idx_ready = 1'b1;
    ticks(80);

    end_req = 1'b1;
    ticks(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/index_walk_scheduler.md
Name: index_walk_scheduler

Overview:
- Shares one index-walk engine between NUM_REQ requesters using round-robin arbitration.
- Each requester submits a job of (base address, index count). The engine latches the job, keeps a down-count of remaining indices, and streams one index address per accepted beat on a valid/ready port. It marks the final beat and pulses a per-requester done.
- Sits between the delta-index producers and the index memory read port.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- ADDR_W, 16, index address width.
- OWNER_W, $clog2(NUM_REQ), owner ID width.
- Count width is `INDEX_NUM_LOG from sys_defs.svh. It is not a parameter.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job pending; held until granted.
- req_count  in  NUM_REQ*`INDEX_NUM_LOG  per-requester index count; slice i = bits [i*`INDEX_NUM_LOG +: `INDEX_NUM_LOG].
- req_base  in  NUM_REQ*ADDR_W  per-requester start address.
- req_grant  out  NUM_REQ  one-hot; high in the cycle requester i's job is latched.
- idx_valid  out  1  index beat valid.
- idx_addr  out  ADDR_W  index address.
- idx_owner  out  OWNER_W  requester that owns the current job.
- idx_last  out  1  current beat is the final beat of the job.
- idx_ready  in  1  downstream accepts the beat.
- done  out  NUM_REQ  one-cycle pulse on bit owner after the job completes.
- busy  out  1  a job is latched (state != IDLE).

Behaviour:
- Reset values: state IDLE; idx_valid, idx_last, done, busy, req_grant = 0; idx_addr, idx_owner, remaining = 0; round-robin pointer = 0.
- Reset mid-job: the job is abandoned, no done is produced, and the pointer returns to 0.
- States: IDLE, ISSUE, ZERO.
- IDLE:
  - req_grant is combinational from req_valid and the pointer.
  - The winner is the first set req_valid bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - In the grant cycle, latch base into cur_addr, count into remaining, and the winner into owner. Set pointer = winner+1 (mod NUM_REQ).
  - Next state: ISSUE if count != 0, else ZERO.
  - With no req_valid set, stay in IDLE and drive no grant.
- ZERO: lasts one cycle; done[owner] = 1, nothing is issued, then return to IDLE.
- ISSUE:
  - idx_valid = 1, idx_addr = cur_addr, idx_last = (remaining == 1).
  - On idx_valid && idx_ready: cur_addr += 1 (wraps modulo 2^ADDR_W) and remaining -= 1.
  - If the accepted beat had idx_last = 1, the next cycle is IDLE with done[owner] = 1 for exactly one cycle.
  - While idx_ready = 0, idx_addr, idx_owner and idx_last hold stable (AXI-style: valid is never withdrawn).
- Latency: first beat appears 1 cycle after grant. There is 1 IDLE cycle between jobs, so done coincides with the next grant cycle.
- Maximum job length is 2^`INDEX_NUM_LOG - 1 beats.
- Requester i must hold req_valid, req_count and req_base stable until req_grant[i] is seen. It may present a new job in the cycle after its grant.
- A requester that is granted is not eligible again until every other valid requester has been served (strict round-robin).

Optional Feature:
- Macro: INDEX_WALK_STRIDE_EN.
- Defined:
  - Adds input req_stride, NUM_REQ*ADDR_W bits, latched at grant.
  - cur_addr advances by the latched stride per accepted beat, modulo 2^ADDR_W.
  - A stride of 0 repeats the same address for every beat.
- Undefined: the port is absent and the address advances by 1.

Test Plan:
- Single job: req_valid=0001, base=0x0100, count=3, idx_ready held 1 -> grant=0001 in cycle 0. Beats in cycles 1-3 carry addr 0x0100/0x0101/0x0102 with idx_last only on the 3rd. done=0001 in cycle 4. busy falls in cycle 4.
- Backpressure: count=2, idx_ready low for 3 cycles on beat 0 -> addr 0x0100 and idx_last=0 held for all 3 stall cycles. Exactly 2 beats are transferred, then done.
- Round-robin: req_valid=1111 held, all count=1 -> grant order 0,1,2,3,0. Each done pulse coincides with the next grant. idx_owner matches each job.
- Zero count and wrap: requester 2 with count=0 -> grant, no idx_valid, done=0100 in the next cycle. Requester 1 with base=0xFFFF, count=2 -> addrs 0xFFFF then 0x0000.
- Reset mid-job: count=5, reset asserted after 2 beats -> no done. All outputs are 0 the cycle after reset. Next grant follows priority from requester 0.
- Stride (INDEX_WALK_STRIDE_EN): base=0x0010, stride=4, count=3 -> addrs 0x0010, 0x0014, 0x0018.
